// File: rtl/karatsuba_recombine_seq_pkg.sv
// Shared types and width helpers for the Karatsuba recombination stage.
package karatsuba_recombine_seq_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StAddZ1 = 3'd1,
    StSubZ0 = 3'd2,
    StSubZ2 = 3'd3,
    StDone  = 3'd4
  } krc_state_e;

  function automatic int unsigned krc_z_bits(input int unsigned half);
    return 2 * half;
  endfunction

  function automatic int unsigned krc_z1_bits(input int unsigned half);
    return 2 * half + 2;
  endfunction

  function automatic int unsigned krc_p_bits(input int unsigned half);
    return 4 * half;
  endfunction

endpackage

// File: rtl/karatsuba_recombine_seq_if.sv
// Partial-product input and product output handshake bundle for the recombination stage.
interface karatsuba_recombine_seq_if
  import karatsuba_recombine_seq_pkg::*;
#(
  parameter int unsigned HALF = 4
);
  localparam int unsigned Z_BITS  = krc_z_bits(HALF);
  localparam int unsigned Z1_BITS = krc_z1_bits(HALF);
  localparam int unsigned P_BITS  = krc_p_bits(HALF);

  logic               in_valid;
  logic               in_ready;
  logic [Z_BITS-1:0]  z0;
  logic [Z1_BITS-1:0] z1;
  logic [Z_BITS-1:0]  z2;
  logic               out_valid;
  logic               out_ready;
  logic [P_BITS-1:0]  p;
  logic               err;

  modport master (
    output in_valid, z0, z1, z2, out_ready,
    input  in_ready, out_valid, p, err
  );

  modport slave (
    input  in_valid, z0, z1, z2, out_ready,
    output in_ready, out_valid, p, err
  );

endinterface

// File: rtl/pos_addsub_shifted.sv
// c = a +/- (b << SHIFT) modulo 2^N_BITS_L; the low SHIFT bits of a pass straight through.
module pos_addsub_shifted #(
  parameter int unsigned N_BITS_L = 16,
  parameter int unsigned N_BITS_R = 10,
  parameter int unsigned SHIFT    = 4
) (
  input  logic [N_BITS_L-1:0] a,
  input  logic [N_BITS_R-1:0] b,
  input  logic                sub,
  output logic [N_BITS_L-1:0] c
);

  localparam int unsigned UBits = N_BITS_L - SHIFT;

  logic [UBits-1:0] b_ext;
  logic [UBits-1:0] hi;

  assign b_ext = UBits'(b);
  assign hi    = sub ? (a[N_BITS_L-1:SHIFT] - b_ext) : (a[N_BITS_L-1:SHIFT] + b_ext);
  assign c     = {hi, a[SHIFT-1:0]};

endmodule

// File: rtl/karatsuba_recombine_seq.sv
// Sequential Karatsuba recombination: P = z2<<2H + (z1-z0-z2)<<H + z0 via one shared shifted adder.
// Define KARATSUBA_RECOMBINE_ERR_EN to flag a negative middle term on err.
module karatsuba_recombine_seq
  import karatsuba_recombine_seq_pkg::*;
#(
  parameter int unsigned HALF = 4
) (
  input logic                    clk,
  input logic                    rst,
  karatsuba_recombine_seq_if.slave bus
);

  localparam int unsigned Z_BITS  = krc_z_bits(HALF);
  localparam int unsigned Z1_BITS = krc_z1_bits(HALF);
  localparam int unsigned P_BITS  = krc_p_bits(HALF);

  krc_state_e         state_q, state_d;
  logic [P_BITS-1:0]  acc_q, acc_d, sum;
  logic [Z_BITS-1:0]  z0_q, z2_q;
  logic [Z1_BITS-1:0] z1_q;
  logic [Z1_BITS-1:0] b_sel;
  logic               sub_sel;
  logic               load;

  pos_addsub_shifted #(
    .N_BITS_L(P_BITS),
    .N_BITS_R(Z1_BITS),
    .SHIFT   (HALF)
  ) u_addsub (
    .a  (acc_q),
    .b  (b_sel),
    .sub(sub_sel),
    .c  (sum)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    b_sel   = z1_q;
    sub_sel = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          // z2 and z0 occupy disjoint bit ranges, so the seed is a plain concatenation.
          acc_d   = {bus.z2, bus.z0};
          load    = 1'b1;
          state_d = StAddZ1;
        end
      end
      StAddZ1: begin
        acc_d   = sum;
        state_d = StSubZ0;
      end
      StSubZ0: begin
        b_sel   = Z1_BITS'(z0_q);
        sub_sel = 1'b1;
        acc_d   = sum;
        state_d = StSubZ2;
      end
      StSubZ2: begin
        b_sel   = Z1_BITS'(z2_q);
        sub_sel = 1'b1;
        acc_d   = sum;
        state_d = StDone;
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      z0_q    <= '0;
      z1_q    <= '0;
      z2_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      if (load) begin
        z0_q <= bus.z0;
        z1_q <= bus.z1;
        z2_q <= bus.z2;
      end
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.p         = (state_q == StDone) ? acc_q : '0;

`ifdef KARATSUBA_RECOMBINE_ERR_EN
  localparam int unsigned MBits = Z1_BITS + 1;

  // Middle term tracked with one extra bit; its MSB acts as the borrow/sign.
  logic [MBits-1:0] mid_q, mid_d;
  logic             err_q, err_d;

  always_comb begin
    mid_d = mid_q;
    err_d = err_q;
    unique case (state_q)
      StAddZ1: mid_d = MBits'(z1_q);
      StSubZ0: mid_d = mid_q - MBits'(z0_q);
      StSubZ2: begin
        mid_d = mid_q - MBits'(z2_q);
        err_d = mid_d[MBits-1];
      end
      StDone:  if (bus.out_ready) err_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mid_q <= '0;
      err_q <= 1'b0;
    end else begin
      mid_q <= mid_d;
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_karatsuba_recombine_seq.sv
// Randomised and directed self-checking bench for karatsuba_recombine_seq (HALF = 4).
module tb_karatsuba_recombine_seq;

  localparam int unsigned HALF = 4;
`ifdef KARATSUBA_RECOMBINE_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  karatsuba_recombine_seq_if #(.HALF(HALF)) bus ();

  karatsuba_recombine_seq #(.HALF(HALF)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Product from the defining formula using wide signed integer arithmetic.
  function automatic logic [15:0] model_p(input int z0, input int z1, input int z2);
    longint v;
    v = (longint'(z2) <<< 8) + ((longint'(z1) - z0 - z2) <<< 4) + z0;
    return 16'(v);
  endfunction

  function automatic logic model_err(input int z0, input int z1, input int z2);
    return ErrEn && ((z1 - z0 - z2) < 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int a, input int b, input int c);
    bus.z0       = 8'(a);
    bus.z1       = 10'(b);
    bus.z2       = 8'(c);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Counts edges from the accept edge (inclusive) until out_valid shows.
  task automatic wait_out(output int lat, output bit ok);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    ok = bus.out_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.z0 = '0; bus.z1 = '0; bus.z2 = '0;
    tick();
    tick();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    checks++;
    if (bus.p !== 16'h0000) begin
      errors++; $display("FAIL reset_p: got %h want 0000", bus.p);
    end
    checks++;
    if (bus.err !== 1'b0) begin
      errors++; $display("FAIL reset_err: got %b want 0", bus.err);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: in_ready=%b out_valid=%b want 1/0",
               bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_nominal();
    int lat;
    bit ok;
    bus.out_ready = 1'b1;
    send(8'h8F, 10'h20D, 8'h78);
    wait_out(lat, ok);
    checks++;
    if (!ok || lat != 4) begin
      errors++; $display("FAIL nominal_latency: got %0d (valid=%b) want 4", lat, ok);
    end
    checks++;
    if (bus.p !== 16'h88EF) begin
      errors++; $display("FAIL nominal_p: got %h want 88ef", bus.p);
    end
    checks++;
    if (bus.err !== 1'b0) begin
      errors++; $display("FAIL nominal_err: got %b want 0", bus.err);
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL nominal_in_ready_done: got %b want 0", bus.in_ready);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL nominal_accept: out_valid=%b in_ready=%b want 0/1",
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_maximum();
    int zt0[2] = '{8'hE1, 0};
    int zt1[2] = '{10'h384, 0};
    int zt2[2] = '{8'hE1, 0};
    logic [15:0] want[2] = '{16'hFE01, 16'h0000};
    int lat;
    bit ok;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      send(zt0[i], zt1[i], zt2[i]);
      wait_out(lat, ok);
      checks++;
      if (!ok || bus.p !== want[i]) begin
        errors++;
        $display("FAIL maximum_p[%0d]: got %h (valid=%b) want %h", i, bus.p, ok, want[i]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit ok;
    int bad;
    bus.out_ready = 1'b0;
    send(8'h8F, 10'h20D, 8'h78);
    wait_out(lat, ok);
    // Offer a second triple while the first result is stalled; it must wait.
    bus.z0 = 8'hE1; bus.z1 = 10'h384; bus.z2 = 8'hE1;
    bus.in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.out_valid !== 1'b1 || bus.p !== 16'h88EF || bus.in_ready !== 1'b0) bad++;
    end
    checks++;
    if (!ok || bad != 0) begin
      errors++;
      $display("FAIL backpressure_hold: bad_cycles=%0d p=%h in_ready=%b want 0/88ef/0",
               bad, bus.p, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b want 0/1",
               bus.out_valid, bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    wait_out(lat, ok);
    checks++;
    if (!ok || lat != 4 || bus.p !== 16'hFE01) begin
      errors++;
      $display("FAIL backpressure_next: got p=%h lat=%0d want fe01 lat 4", bus.p, lat);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int          n_acc, n_out;
    int          cyc_out[2];
    logic [15:0] p_out[2];
    bit          acc_now;
    n_acc = 0;
    n_out = 0;
    cyc_out = '{0, 0};
    p_out = '{16'h0, 16'h0};
    bus.out_ready = 1'b1;
    bus.z0 = 8'h8F; bus.z1 = 10'h20D; bus.z2 = 8'h78;
    bus.in_valid = 1'b1;
    for (int cyc = 0; cyc < 30 && n_out < 2; cyc++) begin
      acc_now = bus.in_ready && bus.in_valid;
      tick();
      if (acc_now) begin
        n_acc++;
        if (n_acc == 1) begin
          bus.z0 = 8'hE1; bus.z1 = 10'h384; bus.z2 = 8'hE1;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      if (bus.out_valid) begin
        p_out[n_out]   = bus.p;
        cyc_out[n_out] = cyc;
        n_out++;
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (n_out != 2) begin
      errors++; $display("FAIL b2b_count: got %0d outputs want 2", n_out);
    end
    checks++;
    if (p_out[0] !== 16'h88EF || p_out[1] !== 16'hFE01) begin
      errors++; $display("FAIL b2b_p: got %h,%h want 88ef,fe01", p_out[0], p_out[1]);
    end
    checks++;
    if (cyc_out[1] - cyc_out[0] != 5) begin
      errors++; $display("FAIL b2b_spacing: got %0d cycles want 5", cyc_out[1] - cyc_out[0]);
    end
    tick();
  endtask

  task automatic test_reset_mid_op();
    int lat;
    bit ok;
    int seen;
    bus.out_ready = 1'b1;
    send(8'hE1, 10'h384, 8'hE1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.p !== 16'h0 ||
        bus.err !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state: out_valid=%b in_ready=%b p=%h err=%b want 0/1/0000/0",
               bus.out_valid, bus.in_ready, bus.p, bus.err);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL midreset_no_emit: got %0d valid cycles want 0", seen);
    end
    send(8'h8F, 10'h20D, 8'h78);
    wait_out(lat, ok);
    checks++;
    if (!ok || bus.p !== 16'h88EF) begin
      errors++; $display("FAIL midreset_next: got %h (valid=%b) want 88ef", bus.p, ok);
    end
    tick();
  endtask

  task automatic test_err();
    int lat;
    bit ok;
    bus.out_ready = 1'b1;
    send(1, 0, 1);
    wait_out(lat, ok);
    checks++;
    if (!ok || bus.p !== model_p(1, 0, 1)) begin
      errors++; $display("FAIL err_p: got %h (valid=%b) want %h", bus.p, ok, model_p(1, 0, 1));
    end
    checks++;
    if (bus.err !== model_err(1, 0, 1)) begin
      errors++; $display("FAIL err_flag: got %b want %b", bus.err, model_err(1, 0, 1));
    end
    tick();
    checks++;
    if (bus.err !== 1'b0) begin
      errors++; $display("FAIL err_clear: got %b want 0", bus.err);
    end
  endtask

  task automatic test_random();
    int x, y, a, b, c, lat, stall;
    bit ok;
    for (int i = 0; i < 24; i++) begin
      if (i % 2 == 0) begin
        x = int'($urandom_range(0, 255));
        y = int'($urandom_range(0, 255));
        a = (x % 16) * (y % 16);
        c = (x / 16) * (y / 16);
        b = ((x % 16) + (x / 16)) * ((y % 16) + (y / 16));
      end else begin
        a = int'($urandom_range(0, 255));
        b = int'($urandom_range(0, 1023));
        c = int'($urandom_range(0, 255));
      end
      bus.out_ready = 1'b0;
      send(a, b, c);
      wait_out(lat, ok);
      stall = int'($urandom_range(0, 3));
      for (int s = 0; s < stall; s++) tick();
      checks++;
      if (!ok || bus.p !== model_p(a, b, c)) begin
        errors++;
        $display("FAIL random_p[%0d]: z0=%h z1=%h z2=%h got %h want %h",
                 i, a, b, c, bus.p, model_p(a, b, c));
      end
      checks++;
      if (bus.err !== model_err(a, b, c)) begin
        errors++;
        $display("FAIL random_err[%0d]: got %b want %b", i, bus.err, model_err(a, b, c));
      end
      bus.out_ready = 1'b1;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_maximum();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    test_err();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
